// File: rtl/spi_txn_sequencer_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// State encoding, dummy byte and read-length clamp used by the sequencer and arbiter.
package spi_txn_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StXfer  = 3'd2,
    StGapW  = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

  localparam logic [7:0] DummyByte = 8'h00;
  localparam logic [2:0] MaxRdLen  = 3'd4;
  localparam int unsigned TmoW     = 10;

  // Lengths 5..7 collapse to the 4-byte result word.
  function automatic logic [2:0] clamp_rd_len(input logic [2:0] len);
    return (len > MaxRdLen) ? MaxRdLen : len;
  endfunction

endpackage

// File: rtl/spi_txn_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: picks the lowest requester at or after last_grant+1.
// The sequencer registers the resulting grant.
module spi_txn_sequencer_rr_arbiter
  import spi_txn_sequencer_pkg::*;
#(
  parameter int unsigned NDEV = 2,
  parameter int unsigned IW   = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic [NDEV-1:0] i_req,
  input  logic [IW-1:0]   i_last_grant,
  output logic [NDEV-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    // Scan starts one past the last grant and wraps; last_grant itself is tried last.
    for (int k = 1; k <= int'(NDEV); k++) begin
      w_cand = IW'((int'(i_last_grant) + k) % int'(NDEV));
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Round-robin register-read sequencer in front of a byte-level SPI master:
// command byte, rd_len dummy bytes, returned bytes packed little-endian into rdata.
module spi_txn_sequencer
  import spi_txn_sequencer_pkg::*;
#(
  parameter int unsigned NDEV     = 2,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned GAP      = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDEV-1:0]   i_req,
  input  logic [8*NDEV-1:0] i_cmd,
  input  logic [3*NDEV-1:0] i_rd_len,
  output logic [NDEV-1:0]   o_ack,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic [NDEV-1:0]   o_cs_n,
  output logic              o_spi_start,
  output logic [7:0]        o_spi_data_in,
  output logic              o_spi_ss,
  input  logic              i_spi_new_data,
  input  logic [7:0]        i_spi_data_out
);

  localparam int unsigned IW     = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int unsigned CntMax = (CS_SETUP > GAP) ? CS_SETUP : GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  seq_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [NDEV-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [7:0]      r_cmd, w_cmd_nxt;
  logic [2:0]      r_len, w_len_nxt;
  logic [2:0]      r_byte, w_byte_nxt;
  logic [31:0]     r_res, w_res_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [TmoW-1:0] r_tmo, w_tmo_nxt;
  logic [NDEV-1:0] r_cs_n, w_cs_n_nxt;
  logic            r_ss, w_ss_nxt;
  logic            r_start, w_start_nxt;
  logic [7:0]      r_data_in, w_data_in_nxt;
  logic [NDEV-1:0] r_ack, w_ack_nxt;
  logic            r_err, w_err_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;

  logic [NDEV-1:0] w_arb_grant;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_valid;
  logic [7:0]      w_cmd_sel;
  logic [2:0]      w_len_sel;
  logic [31:0]     w_res_upd;
  logic            w_finish;
  logic            w_timeout;

  spi_txn_sequencer_rr_arbiter #(
    .NDEV (NDEV),
    .IW   (IW)
  ) u_arb (
    .i_req        (i_req),
    .i_last_grant (r_last),
    .o_grant      (w_arb_grant),
    .o_idx        (w_arb_idx),
    .o_valid      (w_arb_valid)
  );

  always_comb begin
    w_cmd_sel = '0;
    w_len_sel = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (w_arb_grant[i]) begin
        w_cmd_sel = i_cmd[8*i +: 8];
        w_len_sel = i_rd_len[3*i +: 3];
      end
    end
  end

  // Byte 0 is the command slot; its returned byte is discarded.
  always_comb begin
    w_res_upd = r_res;
    case (r_byte)
      3'd1:    w_res_upd[7:0]   = i_spi_data_out;
      3'd2:    w_res_upd[15:8]  = i_spi_data_out;
      3'd3:    w_res_upd[23:16] = i_spi_data_out;
      3'd4:    w_res_upd[31:24] = i_spi_data_out;
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gnt_nxt     = r_gnt;
    w_last_nxt    = r_last;
    w_cmd_nxt     = r_cmd;
    w_len_nxt     = r_len;
    w_byte_nxt    = r_byte;
    w_res_nxt     = r_res;
    w_cnt_nxt     = r_cnt;
    w_tmo_nxt     = r_tmo;
    w_cs_n_nxt    = r_cs_n;
    w_ss_nxt      = r_ss;
    w_start_nxt   = r_start;
    w_data_in_nxt = r_data_in;
    w_ack_nxt     = '0;
    w_err_nxt     = r_err;
    w_rdata_nxt   = r_rdata;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_arb_valid) begin
          w_state_nxt = StSetup;
          w_idx_nxt   = w_arb_idx;
          w_gnt_nxt   = w_arb_grant;
          w_cmd_nxt   = w_cmd_sel;
          w_len_nxt   = clamp_rd_len(w_len_sel);
          w_byte_nxt  = '0;
          w_res_nxt   = '0;
          w_cnt_nxt   = CntW'(CS_SETUP);
          w_cs_n_nxt  = ~w_arb_grant;
          w_ss_nxt    = 1'b0;
        end
      end

      StSetup: begin
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt   = StXfer;
          w_start_nxt   = 1'b1;
          w_data_in_nxt = r_cmd;
          w_tmo_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end

      StXfer: begin
        if (i_spi_new_data) begin
          w_res_nxt  = w_res_upd;
          w_byte_nxt = r_byte + 3'd1;
          // Total bytes on the wire is rd_len + 1 (command plus reads).
          if (r_byte == r_len) begin
            w_finish = 1'b1;
          end else begin
            w_state_nxt = StGapW;
            w_start_nxt = 1'b0;
            w_cnt_nxt   = CntW'(GAP);
          end
        end else if (r_tmo == TmoW'(TIMEOUT)) begin
          w_finish  = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TmoW'(1);
        end

        if (w_finish) begin
          w_state_nxt = StDone;
          w_start_nxt = 1'b0;
          w_cs_n_nxt  = '1;
          w_ss_nxt    = 1'b1;
          w_ack_nxt   = r_gnt;
          w_err_nxt   = w_timeout;
          w_rdata_nxt = w_res_nxt;
        end
      end

      StGapW: begin
        if (r_cnt <= CntW'(1)) begin
          w_state_nxt   = StXfer;
          w_start_nxt   = 1'b1;
          w_data_in_nxt = DummyByte;
          w_tmo_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt - CntW'(1);
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
        w_last_nxt  = r_idx;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_last    <= IW'(NDEV - 1);
      r_cmd     <= '0;
      r_len     <= '0;
      r_byte    <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_cs_n    <= '1;
      r_ss      <= 1'b1;
      r_start   <= 1'b0;
      r_data_in <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_last    <= w_last_nxt;
      r_cmd     <= w_cmd_nxt;
      r_len     <= w_len_nxt;
      r_byte    <= w_byte_nxt;
      r_res     <= w_res_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_ss      <= w_ss_nxt;
      r_start   <= w_start_nxt;
      r_data_in <= w_data_in_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  // Masking start in the new_data cycle keeps the master from re-arming as it returns idle.
  assign o_spi_start   = r_start & ~i_spi_new_data;
  assign o_spi_data_in = r_data_in;
  assign o_spi_ss      = r_ss;
  assign o_cs_n        = r_cs_n;
  assign o_ack         = r_ack;
  assign o_err         = r_err;
  assign o_rdata       = r_rdata;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural byte-level SPI master/slave.
// Each comparison is an immediate assertion that counts and reports its failure.
module tb_spi_txn_sequencer;

  localparam int NDEV     = 2;
  localparam int CS_SETUP = 4;
  localparam int GAP      = 2;
  localparam int TIMEOUT  = 1023;
  localparam int BYTE_CYC = 8;

  logic              clk;
  logic              rst;
  logic [NDEV-1:0]   i_req;
  logic [8*NDEV-1:0] i_cmd;
  logic [3*NDEV-1:0] i_rd_len;
  logic [NDEV-1:0]   o_ack;
  logic              o_err;
  logic [31:0]       o_rdata;
  logic [NDEV-1:0]   o_cs_n;
  logic              o_spi_start;
  logic [7:0]        o_spi_data_in;
  logic              o_spi_ss;
  logic              i_spi_new_data;
  logic [7:0]        i_spi_data_out;

  spi_txn_sequencer #(
    .NDEV     (NDEV),
    .CS_SETUP (CS_SETUP),
    .GAP      (GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_cmd          (i_cmd),
    .i_rd_len       (i_rd_len),
    .o_ack          (o_ack),
    .o_err          (o_err),
    .o_rdata        (o_rdata),
    .o_cs_n         (o_cs_n),
    .o_spi_start    (o_spi_start),
    .o_spi_data_in  (o_spi_data_in),
    .o_spi_ss       (o_spi_ss),
    .i_spi_new_data (i_spi_new_data),
    .i_spi_data_out (i_spi_data_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Master/slave model state
  logic [7:0]      resp [0:4];
  logic [7:0]      mosi [0:7];
  int              bpos = 0;
  bit              busy = 0;
  int              bcnt = 0;
  int              nd_count = 0;
  int              last_nd_cyc = 0;
  int              last_start_cyc = 0;
  int              first_start_cyc = 0;
  int              gap_run = 0;
  int              min_gap = 999;
  int              block_from = 99;
  int              cs_viol = 0;
  int              mask_viol = 0;
  logic            prev_start = 1'b0;
  logic [NDEV-1:0] prev_cs = '1;

  // Results of wait_ack
  bit              got_ack;
  logic [NDEV-1:0] ack_vec;
  logic            ack_err;
  logic [31:0]     ack_rdata;
  int              ack_cyc;
  logic [NDEV-1:0] cs_at_ack;
  int              cs_breaks;
  int              cs_fall_cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    i_spi_new_data = 1'b0;
    i_spi_data_out = 8'h00;
    forever begin
      logic s;
      @(negedge clk);
      s = o_spi_start;
      if (!rst) begin
        busy = 0;
        i_spi_new_data = 1'b0;
        prev_start = 1'b0;
        prev_cs = '1;
        gap_run = 0;
      end else begin
        if (prev_cs == '1 && o_cs_n != '1) begin
          bpos = 0;
          nd_count = 0;
          min_gap = 999;
        end
        if ($countones(~o_cs_n) > 1) cs_viol++;
        if (prev_cs != '1 && o_cs_n != '1 && prev_cs != o_cs_n) cs_viol++;
        i_spi_new_data = 1'b0;
        if (busy) begin
          bcnt++;
          if (bcnt == BYTE_CYC) begin
            i_spi_new_data = 1'b1;
            i_spi_data_out = resp[(bpos > 4) ? 4 : bpos];
            bpos++;
            busy = 0;
            nd_count++;
            last_nd_cyc = cyc;
          end
        end else if (s && !prev_start) begin
          last_start_cyc = cyc;
          if (bpos == 0) first_start_cyc = cyc;
          else if (gap_run < min_gap) min_gap = gap_run;
          if (bpos < block_from) begin
            busy = 1;
            bcnt = 0;
            mosi[bpos] = o_spi_data_in;
          end
        end
        gap_run = s ? 0 : gap_run + 1;
        prev_start = s;
        prev_cs = o_cs_n;
        if (i_spi_new_data) begin
          #1;
          if (o_spi_start !== 1'b0) mask_viol++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int dev, input logic [7:0] c, input logic [2:0] l);
    i_cmd[8*dev +: 8]    = c;
    i_rd_len[3*dev +: 3] = l;
    i_req[dev]           = 1'b1;
  endtask

  task automatic wait_ack(input int dev, input int budget);
    bit seen_low;
    seen_low  = 0;
    got_ack   = 0;
    cs_breaks = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (o_ack != '0) begin
        got_ack   = 1;
        ack_vec   = o_ack;
        ack_err   = o_err;
        ack_rdata = o_rdata;
        ack_cyc   = cyc;
        cs_at_ack = o_cs_n;
        break;
      end
      if (o_cs_n[dev] == 1'b0) seen_low = 1;
      else if (seen_low) cs_breaks++;
    end
  endtask

  task automatic run_txn(input int dev, input logic [7:0] c, input logic [2:0] l, input int budget);
    start_req(dev, c, l);
    wait_ack(dev, budget);
    i_req[dev] = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    i_req    = '0;
    i_cmd    = '0;
    i_rd_len = '0;
    for (int i = 0; i < 5; i++) resp[i] = 8'hEE;
    for (int i = 0; i < 8; i++) mosi[i] = 8'hXX;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_cs_n", 32'(o_cs_n), 32'h3);
    chk("reset_ss", 32'(o_spi_ss), 32'h1);
    chk("reset_start", 32'(o_spi_start), 32'h0);
    chk("reset_data_in", 32'(o_spi_data_in), 32'h0);
    chk("reset_ack", 32'(o_ack), 32'h0);
    chk("reset_err", 32'(o_err), 32'h0);
    chk("reset_rdata", o_rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single read
    resp[1] = 8'h58;
    start_req(0, 8'hD0, 3'd1);
    @(negedge clk);
    cs_fall_cyc = cyc;
    chk("grant_latency_cs_n", 32'(o_cs_n), 32'h2);
    chk("grant_ss", 32'(o_spi_ss), 32'h0);
    wait_ack(0, 200);
    i_req[0] = 1'b0;
    chk("single_got_ack", 32'(got_ack), 32'h1);
    chk("single_ack_vec", 32'(ack_vec), 32'h1);
    chk("single_err", 32'(ack_err), 32'h0);
    chk("single_rdata", ack_rdata, 32'h0000_0058);
    chk("single_nd_count", nd_count, 2);
    chk("single_mosi0", 32'(mosi[0]), 32'hD0);
    chk("single_mosi1", 32'(mosi[1]), 32'h00);
    chk("single_setup_cycles", first_start_cyc - cs_fall_cyc, CS_SETUP);
    chk("single_ack_latency", ack_cyc - last_nd_cyc, 1);
    chk("single_cs_at_ack", 32'(cs_at_ack), 32'h3);
    chk("single_cs_held_low", cs_breaks, 0);
    @(negedge clk);
    chk("rdata_held_after_ack", o_rdata, 32'h0000_0058);

    // 4-byte burst
    resp[1] = 8'h11; resp[2] = 8'h22; resp[3] = 8'h33; resp[4] = 8'h44;
    run_txn(0, 8'h3B, 3'd4, 400);
    chk("burst_got_ack", 32'(got_ack), 32'h1);
    chk("burst_rdata", ack_rdata, 32'h4433_2211);
    chk("burst_nd_count", nd_count, 5);
    chk("burst_min_gap_ok", 32'(min_gap >= GAP), 32'h1);
    chk("burst_mosi0", 32'(mosi[0]), 32'h3B);
    chk("burst_mosi4", 32'(mosi[4]), 32'h00);

    // rd_len 0: command-only write
    run_txn(1, 8'h0F, 3'd0, 200);
    chk("len0_got_ack", 32'(got_ack), 32'h1);
    chk("len0_ack_vec", 32'(ack_vec), 32'h2);
    chk("len0_rdata", ack_rdata, 32'h0);
    chk("len0_nd_count", nd_count, 1);
    chk("len0_mosi0", 32'(mosi[0]), 32'h0F);

    // rd_len 7 treated as 4
    resp[1] = 8'h01; resp[2] = 8'h02; resp[3] = 8'h03; resp[4] = 8'h04;
    run_txn(0, 8'hC7, 3'd7, 400);
    chk("len7_got_ack", 32'(got_ack), 32'h1);
    chk("len7_rdata", ack_rdata, 32'h0403_0201);
    chk("len7_nd_count", nd_count, 5);

    // Timeout on the third byte; partial result kept
    resp[1] = 8'h9A;
    block_from = 2;
    run_txn(1, 8'hE1, 3'd3, 1400);
    block_from = 99;
    chk("tmo_got_ack", 32'(got_ack), 32'h1);
    chk("tmo_ack_vec", 32'(ack_vec), 32'h2);
    chk("tmo_err", 32'(ack_err), 32'h1);
    chk("tmo_rdata_partial", ack_rdata, 32'h0000_009A);
    chk("tmo_cycles", ack_cyc - last_start_cyc, TIMEOUT + 1);
    chk("tmo_cs_at_ack", 32'(cs_at_ack), 32'h3);

    resp[1] = 8'h77;
    run_txn(1, 8'hE2, 3'd1, 200);
    chk("post_tmo_got_ack", 32'(got_ack), 32'h1);
    chk("post_tmo_err", 32'(ack_err), 32'h0);
    chk("post_tmo_rdata", ack_rdata, 32'h0000_0077);

    // Reset during byte 2 of a burst
    start_req(0, 8'h3B, 3'd4);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bpos == 2 && busy) break;
    end
    chk("rst_reached_byte2", bpos, 2);
    rst = 1'b0;
    i_req = '0;
    #1;
    chk("rst_cs_n", 32'(o_cs_n), 32'h3);
    chk("rst_start", 32'(o_spi_start), 32'h0);
    chk("rst_ss", 32'(o_spi_ss), 32'h1);
    wait_ack(0, 5);
    chk("rst_no_ack", 32'(got_ack), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    resp[1] = 8'h3C;
    run_txn(1, 8'h55, 3'd1, 200);
    chk("post_rst_got_ack", 32'(got_ack), 32'h1);
    chk("post_rst_ack_vec", 32'(ack_vec), 32'h2);
    chk("post_rst_rdata", ack_rdata, 32'h0000_003C);

    // Contention: alternating grants starting at device 0
    resp[1] = 8'h5A;
    start_req(0, 8'hA1, 3'd1);
    start_req(1, 8'hB2, 3'd1);
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, 400);
      if (k == 3) i_req = '0;
      chk("rr_got_ack", 32'(got_ack), 32'h1);
      chk("rr_ack_vec", 32'(ack_vec), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_cmd_byte", 32'(mosi[0]), (k % 2 == 0) ? 32'hA1 : 32'hB2);
      chk("rr_rdata", ack_rdata, 32'h0000_005A);
    end
    repeat (4) @(negedge clk);
    chk("rr_idle_after", 32'(o_cs_n), 32'h3);
    chk("cs_exclusive_and_gapped", cs_viol, 0);
    chk("start_masked_on_new_data", mask_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_txn_sequencer.md
# spi_txn_sequencer

Multi-requester transaction sequencer in front of the byte-level `spi_master`. It accepts register-read transactions from up to `NDEV` sensor pollers (IMU, barometer, …) and arbitrates among them round-robin. For the granted requester it drives that device's chip select, sends the command byte, clocks out the requested number of dummy bytes and packs the returned bytes into one result word. It owns `spi_master`'s `start`/`data_in`/`ss` inputs; nothing else drives them.

## Interface
Parameters:
- `NDEV`, 2: number of requesters/devices (1..4); requester i maps to device i.
- `CS_SETUP`, 4: clk cycles from `cs_n` low to the first byte start (≥1).
- `GAP`, 2: idle clk cycles between bytes within a transaction (≥1).
- `TIMEOUT`, 1023: max clk cycles waiting for `spi_new_data` per byte; 10-bit counter.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NDEV: level request per requester; held until its `ack`.
- `cmd` in 8*NDEV: command byte of requester i at `[8i+7:8i]`; sampled at grant.
- `rd_len` in 3*NDEV: read byte count for requester i (0..4; values 5..7 are treated as 4); sampled at grant.
- `ack` out NDEV: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with `ack`; 1 means the transaction timed out.
- `rdata` out 32: result; first read byte in `[7:0]`, second in `[15:8]`, and so on; unused bytes are 0; valid with `ack` and held until the next `ack`.
- `cs_n` out NDEV: per-device chip select, active low.
- `spi_start` out 1: to `spi_master.start`.
- `spi_data_in` out 8: to `spi_master.data_in`.
- `spi_ss` out 1: to `spi_master.ss`; 0 enables the master.
- `spi_new_data` in 1: from `spi_master.new_data`; one-cycle end-of-byte pulse.
- `spi_data_out` in 8: from `spi_master.data_out`; valid with `spi_new_data`.

## Operation
- States: `IDLE`, `SETUP`, `XFER`, `GAP_W`, `DONE`.
- `IDLE`: if any `req` bit is set, grant the lowest index at or after `last_grant+1` (mod NDEV). Latch index, cmd and len; clear the byte counter and result; drive `cs_n[idx]`=0 and `spi_ss`=0. Go to `SETUP` with the counter set to `CS_SETUP`.
- `SETUP`: count down, then go to `XFER`.
- `XFER`: `spi_start_q`=1 and `spi_data_in` = cmd for byte 0, or 8'h00 for later bytes. The timeout counter runs.
  - On `spi_new_data`: if byte index ≥1, write `spi_data_out` into result byte (index−1). Increment the index.
  - If index == len, go to `DONE`; otherwise go to `GAP_W`.
  - On timeout: set the error flag and go to `DONE`.
- `GAP_W`: hold `spi_start`=0 for `GAP` cycles, then go to `XFER`.
- `DONE`: deassert `cs_n` and set `spi_ss`=1. Pulse `ack[idx]`, drive `err` and update `rdata`. Set `last_grant`=idx and return to `IDLE`.
- `spi_start = spi_start_q & ~spi_new_data`. This combinational mask guarantees the master, which returns to IDLE in the `new_data` cycle, never sees `start` and re-arms.
- A transaction with len 0 is a command-only write: 1 byte, `rdata`=0.
- A requester that drops `req` mid-transaction does not abort it; its `ack` still fires.

## Timing
- Reset values: `cs_n` all 1, `spi_ss`=1, `spi_start`=0, `spi_data_in`=0, `ack`=0, `err`=0, `rdata`=0, `last_grant`=NDEV−1, state `IDLE`.
- Reset mid-transaction: all outputs take their reset values immediately (asynchronous). No `ack` is issued.
- Grant is registered: `cs_n` falls 1 cycle after `req` rises with the block idle.
- `spi_start` rises `CS_SETUP` cycles after `cs_n` falls.
- `ack` fires 1 cycle after the final `spi_new_data`. `cs_n` rises in the same cycle as `ack`.
- After `ack`, at least 1 `IDLE` cycle occurs before the next grant, so `cs_n` is high for at least 1 cycle between transactions.
- Timeout: the counter resets on entry to `XFER`. Reaching `TIMEOUT` without `new_data` gives `ack` with `err`=1 on the next cycle, and `rdata` holds the partial result.
- `spi_data_in` is stable for the whole `XFER` interval.

## Structure
- Shared package `spi_pkg`: state encoding localparams and the dummy byte value 8'h00.
- Sub-module `rr_arbiter` (NDEV-wide, inputs `req` and `last_grant`, outputs one-hot grant plus index). It is pure combinational; the grant is registered in the sequencer.
- The top-level integrates `spi_txn_sequencer` + `spi_master`. The master's `busy`/`chip_rdy` are not used by this block.

## Test plan
- Single read, NDEV=2: req[0], cmd=8'hD0, rd_len=1, slave returns 8'h58 → two bytes on MOSI (D0, 00); `ack[0]` with `rdata`=32'h00000058, `err`=0, `cs_n[0]` low throughout.
- 4-byte burst: rd_len=4, slave bytes 11,22,33,44 after the cmd byte → `rdata`=32'h44332211; exactly 5 `spi_new_data` pulses; `spi_start` low for ≥`GAP` cycles between bytes.
- Contention: req=2'b11 held → grants alternate 0,1,0,1; `cs_n` never has both bits low; a ≥1-cycle gap with all `cs_n` high between transactions.
- Timeout: block `spi_new_data` after the cmd byte → after 1023 cycles `ack` with `err`=1; `cs_n` high; the next request is served normally.
- Reset mid-burst: drop `rst` during byte 2 → `cs_n`=all 1, `spi_start`=0, no `ack`; after release, a new req[1] completes correctly.
- rd_len=0 and rd_len=7: 0 → one byte and `rdata`=0; 7 → exactly 5 bytes, treated as 4.
